// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round constants, controller states and GF(2^8) helpers.
package aes_pkg;

    localparam int NR = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8), reducing by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product by shift-and-xor.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one.
module aes_key_step (
    input  logic [127:0] rk_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] next_rk_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w, tmp_w;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = rk_i[127:96];
    assign w1 = rk_i[95:64];
    assign w2 = rk_i[63:32];
    assign w3 = rk_i[31:0];

    // RotWord moves the top byte of w3 to the bottom.
    assign rot_w = {w3[23:0], w3[31:24]};

    // Dedicated S-boxes keep the key path independent of the shared state SubBytes.
    for (genvar i = 0; i < 4; i++) begin : g_sw
        sbox u_sbox (
            .a_i (rot_w[8*i +: 8]),
            .s_o (sub_w[8*i +: 8])
        );
    end

    assign tmp_w = sub_w ^ {rcon_i, 24'h000000};
    assign n0    = w0 ^ tmp_w;
    assign n1    = w1 ^ n0;
    assign n2    = w2 ^ n1;
    assign n3    = w3 ^ n2;

    assign next_rk_o = {n0, n1, n2, n3};

endmodule

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    // a^254 is the inverse for nonzero a and maps 0 to 0, as the S-box requires.
    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] base;
        logic [7:0] inv;
        base = a;
        inv  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            inv  = gf_mul(inv, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign s_o = sbox_f(a_i);

endmodule

// File: rtl/subbytes.sv
// SubBytes over a full 128-bit state: sixteen independent S-boxes.
module subbytes (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    for (genvar i = 0; i < 16; i++) begin : g_sb
        sbox u_sbox (
            .a_i (state_i[8*i +: 8]),
            .s_o (state_o[8*i +: 8])
        );
    end

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, shared SubBytes, on-the-fly key expansion.
module aes_enc_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic [3:0]   round
);

    aes_state_e   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] sb_out, sr_out, mc_out, next_rk;
    logic [7:0]   rcon;

    // Byte (row r, column c) sits at index 4c+r, with byte 0 in the top bits.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    subbytes u_subbytes (
        .state_i (state_q),
        .state_o (sb_out)
    );

    aes_key_step u_key_step (
        .rk_i      (rk_q),
        .rcon_i    (rcon),
        .next_rk_o (next_rk)
    );

    assign sr_out = shift_rows(sb_out);
    assign mc_out = mix_columns(sr_out);

    // Round constant for the current round; outside 1..10 the key step output is unused.
    always_comb begin
        rcon = 8'h00;
        if (round_q >= 4'd1 && round_q <= 4'(NR)) rcon = RCON[round_q];
    end

    // Next-state logic: accept in IDLE, one round per cycle in RUN, hold result in DONE.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = plaintext ^ key;
                    rk_d    = key;
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                rk_d    = next_rk;
                round_d = (round_q >= 4'(NR)) ? 4'(NR) : round_q + 4'd1;
                if (round_q == 4'(NR)) begin
                    state_d = sr_out ^ next_rk;
                    fsm_d   = DONE;
                end else begin
                    state_d = mc_out ^ next_rk;
                end
            end
            DONE: begin
                if (out_ready) begin
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State, key and round registers; reset discards any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
        end
    end

    // Handshake flags decode the state register only, so out_ready never reaches in_ready.
    assign in_ready   = (fsm_q == IDLE);
    assign out_valid  = (fsm_q == DONE);
    assign busy       = (fsm_q == RUN);
    assign round      = round_q;
    assign ciphertext = state_q;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Directed bench for aes_enc_ctrl using the FIPS-197 Appendix B and C.1 vectors.
module tb_aes_enc_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    aes_enc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round      (round)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"},  in_ready,   1);
        check({tag, ".out_valid"}, out_valid,  0);
        check({tag, ".busy"},      busy,       0);
        check({tag, ".round"},     round,      0);
        check({tag, ".ct"},        ciphertext, 0);
    endtask

    // Sends one block from IDLE, optionally scrambling inputs during RUN, then drains it.
    task automatic run_one(input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input bit noisy, input string tag);
        int lat;
        bit seen;
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        check({tag, ".acc_busy"},  busy,  1);
        check({tag, ".acc_round"}, round, 1);
        in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            if (noisy) begin
                in_valid  = 1'($urandom_range(0, 1));
                plaintext = {$urandom, $urandom, $urandom, $urandom};
                key       = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            if (out_valid) begin
                seen = 1'b1;
                lat  = i;
            end else if (noisy) begin
                check({tag, ".no_accept"}, in_ready, 0);
            end
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, lat, 10);
        check({tag, ".ct"}, ciphertext, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".drain_valid"}, out_valid, 0);
        check({tag, ".drain_ready"}, in_ready,  1);
    endtask

    initial begin
        int acc1;
        int acc2;
        int nres;
        logic [127:0] res [2];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key       = '0;
        res[0]    = '0;
        res[1]    = '0;
        tick();
        tick();
        check_reset_outputs("reset");

        // Vector 1, presented in the same cycle reset is released.
        rst       = 1'b0;
        in_valid  = 1'b1;
        plaintext = P1;
        key       = K1;
        tick();
        check("v1.acc_busy",  busy,     1);
        check("v1.acc_round", round,    1);
        check("v1.acc_ready", in_ready, 0);
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("v1.round%0d", i), round, (i < 10) ? i + 1 : 10);
            check($sformatf("v1.valid%0d", i), out_valid, (i == 10) ? 1 : 0);
        end
        check("v1.ct", ciphertext, C1);

        // Backpressure: out_ready stays low for the first 7 DONE cycles.
        for (int i = 2; i <= 7; i++) begin
            tick();
            check($sformatf("bp.ct%0d", i),    ciphertext, C1);
            check($sformatf("bp.valid%0d", i), out_valid,  1);
            check($sformatf("bp.ready%0d", i), in_ready,   0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.done_valid", out_valid, 0);
        check("bp.done_ready", in_ready,  1);
        check("bp.done_round", round,     0);

        run_one(P2, K2, C2, 1'b0, "v2");
        run_one(P1, K1, C1, 1'b1, "noisy");

        // Back-to-back with in_valid held and out_ready high.
        out_ready = 1'b1;
        plaintext = P1;
        key       = K1;
        in_valid  = 1'b1;
        acc1 = -1;
        acc2 = -1;
        nres = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy && round == 4'd1) begin
                if (acc1 < 0) begin
                    acc1      = i;
                    plaintext = P2;
                    key       = K2;
                end else if (acc2 < 0) begin
                    acc2     = i;
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (nres < 2) res[nres] = ciphertext;
                nres++;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b.count",   nres,        2);
        check("b2b.ct1",     res[0],      C1);
        check("b2b.ct2",     res[1],      C2);
        check("b2b.spacing", acc2 - acc1, 12);

        // Reset in the middle of round 5.
        plaintext = P1;
        key       = K1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && round != 4'd5; i++) tick();
        check("rst.reached5", round, 5);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst.async");
        tick();
        check_reset_outputs("rst.held");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst.idle_valid%0d", i), out_valid, 0);
            check($sformatf("rst.idle_ready%0d", i), in_ready,  1);
        end
        run_one(P2, K2, C2, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_enc_ctrl.md
# aes_enc_ctrl

Iterative AES-128 encryption sequencer that reuses one `subbytes` instance (16 S-boxes) for all ten rounds and expands the round key on the fly, one round per clock. It accepts a plaintext/key pair over a valid/ready handshake, runs the initial AddRoundKey plus rounds 1–10, and holds the ciphertext until the consumer takes it. It sits between the host-side block buffer and the output FIFO of the encryption path.

## Interface
Parameters: none. The block is fixed to AES-128 with Nr = 10.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  plaintext/key pair present
- `in_ready`  out  1  block can accept a pair
- `plaintext`  in  128  byte 0 = [127:120], column-major per FIPS-197
- `key`  in  128  cipher key, same byte order
- `out_valid`  out  1  ciphertext available
- `out_ready`  in  1  consumer takes ciphertext
- `ciphertext`  out  128  result, same byte order
- `busy`  out  1  high in RUN
- `round`  out  4  current round index, 0–10

## Operation
FSM states: IDLE, RUN, DONE.

IDLE
- `in_ready` = 1.
- On `in_valid` && `in_ready`:
  - state_reg ← plaintext ^ key (round 0).
  - rk_reg ← key.
  - round ← 1.
  - go to RUN.

RUN (one round per cycle, r = `round`)
- next_rk = KeyStep(rk_reg, Rcon[r]):
  - RotWord then SubWord on w3, XOR with Rcon, then XOR chain through w0..w3.
  - SubWord uses 4 dedicated S-boxes, not the shared `subbytes`.
- r in 1..9:
  - state_reg ← MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_rk.
- r = 10:
  - MixColumns is bypassed.
  - state_reg ← ShiftRows(SubBytes(state_reg)) ^ next_rk.
  - Go to DONE.
- Every RUN cycle: rk_reg ← next_rk; round ← r+1, saturating at 10.
- `in_valid` is ignored while in RUN.

DONE
- `out_valid` = 1.
- `ciphertext` = state_reg. It stays stable while `out_valid` && !`out_ready`.
- On `out_ready`: go to IDLE; `round` ← 0.

General rules
- There is exactly one `subbytes` instance. Its input is state_reg in every cycle. Its output is consumed only in RUN.
- MixColumns uses GF(2^8) xtime with reduction polynomial 0x11B. All byte arithmetic is 8-bit XOR; there are no carries.
- `ciphertext` is driven from state_reg in every state. Only `out_valid` qualifies it.

## Timing
- Reset values:
  - FSM = IDLE, `in_ready` = 1, `out_valid` = 0, `busy` = 0, `round` = 0.
  - state_reg = 0, so `ciphertext` = 0; rk_reg = 0.
- Latency: the acceptance edge is E0. Rounds complete on edges E1..E10. `out_valid` rises after E10, i.e. 10 cycles after acceptance.
- Throughput: no overlap between blocks. Minimum spacing is 12 cycles per block (accept, 10 rounds, 1 DONE cycle with `out_ready` = 1).
- `in_ready` is a registered decode of IDLE. It has no combinational path from `out_ready`.
- `out_valid` must not drop until the handshake completes.
- Back-to-back: a DONE→IDLE transition at edge Ek allows acceptance at edge Ek+1 at the earliest.
- Reset asserted mid-RUN or in DONE:
  - Aborts immediately; the partial state is discarded.
  - Outputs take their reset values asynchronously.
- `in_valid` asserted in the same cycle that reset deasserts: accepted on the first clock edge after deassertion.

## Structure
- Shared package `aes_pkg`:
  - Rcon array [1:10] = 01,02,04,08,10,20,40,80,1B,36.
  - State enum (IDLE/RUN/DONE).
  - `NR` = 10.
  - xtime function.
- Sub-module `aes_key_step`, combinational:
  - Inputs: rk[127:0], rcon[7:0]. Output: next_rk[127:0].
  - Instantiates 4 `sbox`.
- ShiftRows and MixColumns are inline functions in the controller.
- The existing `subbytes` and `sbox` modules are reused unchanged.

## Test plan
1. FIPS-197 App. B vector:
   - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
   - Response: ct 3925841d02dc09fbdc118597196a0b32; `out_valid` exactly 10 cycles after acceptance; `round` steps 1..10.
2. FIPS-197 App. C.1 vector:
   - Stimulus: key 000102…0f, pt 00112233445566778899aabbccddeeff.
   - Response: ct 69c4e0d86a7b0430d8cdb78070b4c55a.
3. Backpressure:
   - Stimulus: hold `out_ready` = 0 for 7 cycles after `out_valid`.
   - Response: ct stable; `in_ready` = 0 throughout; the handshake completes on the 8th cycle.
4. Back-to-back:
   - Stimulus: `in_valid` held high with the vector 1 then vector 2 pairs; `out_ready` = 1.
   - Response: two correct results; the second acceptance occurs exactly 12 cycles after the first.
5. Reset mid-operation:
   - Stimulus: assert `rst` at round 5, release, then send vector 2.
   - Response: outputs at reset values during reset; no spurious `out_valid`; correct vector-2 ct afterwards.
6. Ignored input:
   - Stimulus: toggle `in_valid` and change plaintext during RUN.
   - Response: result unaffected; no acceptance until IDLE.
